// File: rtl/csr_file_if.sv
// CSR file port bundle: execute-stage and interrupt-controller read/write
// ports, instruction-retire pulse, and the direct register views.
interface csr_file_if;
    logic        instret_i;

    logic        ex_we_i;
    logic [31:0] ex_waddr_i;
    logic [31:0] ex_raddr_i;
    logic [31:0] ex_data_i;
    logic [31:0] ex_data_o;

    logic        clint_we_i;
    logic [31:0] clint_waddr_i;
    logic [31:0] clint_raddr_i;
    logic [31:0] clint_data_i;
    logic [31:0] clint_data_o;

    logic [31:0] csr_mtvec_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mstatus_o;
    logic        global_int_en_o;

    // Core / testbench side: drives requests, observes read data and views.
    modport master (
        output instret_i,
        output ex_we_i, ex_waddr_i, ex_raddr_i, ex_data_i,
        input  ex_data_o,
        output clint_we_i, clint_waddr_i, clint_raddr_i, clint_data_i,
        input  clint_data_o,
        input  csr_mtvec_o, csr_mepc_o, csr_mstatus_o, global_int_en_o
    );

    // CSR file side.
    modport slave (
        input  instret_i,
        input  ex_we_i, ex_waddr_i, ex_raddr_i, ex_data_i,
        output ex_data_o,
        input  clint_we_i, clint_waddr_i, clint_raddr_i, clint_data_i,
        output clint_data_o,
        output csr_mtvec_o, csr_mepc_o, csr_mstatus_o, global_int_en_o
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: six plain 32-bit registers plus the 64-bit cycle
// and retired-instruction counters. Two write ports (execute, interrupt
// controller) share a single write slot with execute taking priority; both
// read ports are combinational with same-cycle write bypass.
module csr_file #(
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
    parameter logic [31:0] MSTATUS_RST = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    csr_file_if.slave  bus
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    // The single write accepted this cycle, after arbitration.
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    logic [11:0] ex_waddr;
    logic [11:0] ex_raddr;
    logic [11:0] clint_raddr;

    logic        wr_mcycle_lo;
    logic        wr_mcycle_hi;
    logic        wr_minstret_lo;
    logic        wr_minstret_hi;

    logic [31:0] ex_reg_rdata;
    logic [31:0] clint_reg_rdata;

    // Only the low 12 bits select a CSR; the rest are deliberately dropped.
    logic        unused_addr_bits;

    assign ex_waddr    = bus.ex_waddr_i[11:0];
    assign ex_raddr    = bus.ex_raddr_i[11:0];
    assign clint_raddr = bus.clint_raddr_i[11:0];

    assign unused_addr_bits = ^{bus.ex_waddr_i[31:12], bus.ex_raddr_i[31:12],
                                bus.clint_waddr_i[31:12], bus.clint_raddr_i[31:12]};

    // Register value at a CSR number; unimplemented numbers read as zero.
    function automatic logic [31:0] csr_value(
        input logic [11:0] addr,
        input logic [31:0] v_mstatus,
        input logic [31:0] v_mie,
        input logic [31:0] v_mtvec,
        input logic [31:0] v_mscratch,
        input logic [31:0] v_mepc,
        input logic [31:0] v_mcause,
        input logic [63:0] v_mcycle,
        input logic [63:0] v_minstret
    );
        logic [31:0] val;
        val = 32'h0;
        unique case (addr)
            ADDR_MSTATUS:   val = v_mstatus;
            ADDR_MIE:       val = v_mie;
            ADDR_MTVEC:     val = v_mtvec;
            ADDR_MSCRATCH:  val = v_mscratch;
            ADDR_MEPC:      val = v_mepc;
            ADDR_MCAUSE:    val = v_mcause;
            ADDR_MCYCLE:    val = v_mcycle[31:0];
            ADDR_MCYCLEH:   val = v_mcycle[63:32];
            ADDR_MINSTRET:  val = v_minstret[31:0];
            ADDR_MINSTRETH: val = v_minstret[63:32];
            default:        val = 32'h0;
        endcase
        return val;
    endfunction

    // Arbitrate the two write ports: execute wins, the clint write is dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 12'h0;
        wr_data = 32'h0;
        if (bus.ex_we_i) begin
            wr_en   = 1'b1;
            wr_addr = ex_waddr;
            wr_data = bus.ex_data_i;
        end else if (bus.clint_we_i) begin
            wr_en   = 1'b1;
            wr_addr = bus.clint_waddr_i[11:0];
            wr_data = bus.clint_data_i;
        end
    end

    assign wr_mcycle_lo   = wr_en && (wr_addr == ADDR_MCYCLE);
    assign wr_mcycle_hi   = wr_en && (wr_addr == ADDR_MCYCLEH);
    assign wr_minstret_lo = wr_en && (wr_addr == ADDR_MINSTRET);
    assign wr_minstret_hi = wr_en && (wr_addr == ADDR_MINSTRETH);

    // Plain machine registers: reset values, then load on an accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus  <= MSTATUS_RST;
            mie      <= 32'h0;
            mtvec    <= MTVEC_RST;
            mscratch <= 32'h0;
            mepc     <= 32'h0;
            mcause   <= 32'h0;
        end else if (wr_en) begin
            unique case (wr_addr)
                ADDR_MSTATUS:  mstatus  <= wr_data;
                ADDR_MIE:      mie      <= wr_data;
                ADDR_MTVEC:    mtvec    <= wr_data;
                ADDR_MSCRATCH: mscratch <= wr_data;
                ADDR_MEPC:     mepc     <= wr_data;
                ADDR_MCAUSE:   mcause   <= wr_data;
                default:       ;
            endcase
        end
    end

    // Cycle counter: a write to either half loads that half and skips the
    // increment for the cycle, so no carry reaches the other half.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle <= 64'h0;
        end else if (wr_mcycle_lo) begin
            mcycle[31:0] <= wr_data;
        end else if (wr_mcycle_hi) begin
            mcycle[63:32] <= wr_data;
        end else begin
            mcycle <= mcycle + 64'h1;
        end
    end

    // Retired-instruction counter: same write rule as the cycle counter,
    // counting only on instret pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            minstret <= 64'h0;
        end else if (wr_minstret_lo) begin
            minstret[31:0] <= wr_data;
        end else if (wr_minstret_hi) begin
            minstret[63:32] <= wr_data;
        end else if (bus.instret_i) begin
            minstret <= minstret + 64'h1;
        end
    end

    // Stored values at each port's read address (pre-edge, no increment).
    always_comb begin
        ex_reg_rdata    = csr_value(ex_raddr, mstatus, mie, mtvec, mscratch,
                                    mepc, mcause, mcycle, minstret);
        clint_reg_rdata = csr_value(clint_raddr, mstatus, mie, mtvec, mscratch,
                                    mepc, mcause, mcycle, minstret);
    end

    // Execute read bypass only looks at the execute write, even when that
    // write targets an unimplemented number.
    always_comb begin
        bus.ex_data_o = ex_reg_rdata;
        if (bus.ex_we_i && (ex_waddr == ex_raddr)) begin
            bus.ex_data_o = bus.ex_data_i;
        end
    end

    // Clint read bypass follows whichever write won arbitration.
    always_comb begin
        bus.clint_data_o = clint_reg_rdata;
        if (wr_en && (wr_addr == clint_raddr)) begin
            bus.clint_data_o = wr_data;
        end
    end

    assign bus.csr_mtvec_o     = mtvec;
    assign bus.csr_mepc_o      = mepc;
    assign bus.csr_mstatus_o   = mstatus;
    assign bus.global_int_en_o = mstatus[3];

endmodule

// File: tb/tb_csr_file.sv
// Testbench for csr_file: directed scenarios plus a randomized run, all
// checked against a register-map reference model held in the bench.
module tb_csr_file;

    localparam logic [31:0] MTVEC_RST   = 32'h0000_0080;
    localparam logic [31:0] MSTATUS_RST = 32'h0000_0008;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    csr_file_if bus();

    csr_file #(
        .MTVEC_RST   (MTVEC_RST),
        .MSTATUS_RST (MSTATUS_RST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain registers by CSR number, counters as 64-bit values.
    logic [31:0] m_csr [logic [11:0]];
    logic [63:0] m_cyc;
    logic [63:0] m_ins;

    task automatic model_reset();
        m_csr.delete();
        m_csr[12'h300] = MSTATUS_RST;
        m_csr[12'h304] = 32'h0;
        m_csr[12'h305] = MTVEC_RST;
        m_csr[12'h340] = 32'h0;
        m_csr[12'h341] = 32'h0;
        m_csr[12'h342] = 32'h0;
        m_cyc = 64'h0;
        m_ins = 64'h0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            default: return m_csr.exists(a) ? m_csr[a] : 32'h0;
        endcase
    endfunction

    function automatic logic win_we();
        return bus.ex_we_i | bus.clint_we_i;
    endfunction

    function automatic logic [11:0] win_addr();
        return bus.ex_we_i ? bus.ex_waddr_i[11:0] : bus.clint_waddr_i[11:0];
    endfunction

    function automatic logic [31:0] win_data();
        return bus.ex_we_i ? bus.ex_data_i : bus.clint_data_i;
    endfunction

    function automatic logic [31:0] exp_ex();
        if (bus.ex_we_i && bus.ex_waddr_i[11:0] == bus.ex_raddr_i[11:0])
            return bus.ex_data_i;
        return m_read(bus.ex_raddr_i[11:0]);
    endfunction

    function automatic logic [31:0] exp_clint();
        if (win_we() && win_addr() == bus.clint_raddr_i[11:0])
            return win_data();
        return m_read(bus.clint_raddr_i[11:0]);
    endfunction

    // Advance the model by one edge using the inputs now applied, then wait.
    task automatic cycle();
        logic [63:0] nc;
        logic [63:0] ni;
        logic [11:0] a;
        logic [31:0] d;
        if (rst) begin
            model_reset();
        end else begin
            nc = m_cyc + 64'd1;
            ni = m_ins + (bus.instret_i ? 64'd1 : 64'd0);
            if (win_we()) begin
                a = win_addr();
                d = win_data();
                case (a)
                    12'hB00: nc = {m_cyc[63:32], d};
                    12'hB80: nc = {d, m_cyc[31:0]};
                    12'hB02: ni = {m_ins[63:32], d};
                    12'hB82: ni = {d, m_ins[31:0]};
                    default: if (m_csr.exists(a)) m_csr[a] = d;
                endcase
            end
            m_cyc = nc;
            m_ins = ni;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.instret_i     = 1'b0;
        bus.ex_we_i       = 1'b0;
        bus.ex_waddr_i    = 32'h0;
        bus.ex_raddr_i    = 32'h0;
        bus.ex_data_i     = 32'h0;
        bus.clint_we_i    = 1'b0;
        bus.clint_waddr_i = 32'h0;
        bus.clint_raddr_i = 32'h0;
        bus.clint_data_i  = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        bus.ex_raddr_i    = 32'h300;
        bus.clint_raddr_i = 32'hB00;
        #1;
        n_total++;
        if (bus.csr_mtvec_o !== MTVEC_RST)
            $display("FAIL reset_mtvec got=%h exp=%h", bus.csr_mtvec_o, MTVEC_RST);
        else n_pass++;
        n_total++;
        if (bus.csr_mstatus_o !== MSTATUS_RST)
            $display("FAIL reset_mstatus got=%h exp=%h", bus.csr_mstatus_o, MSTATUS_RST);
        else n_pass++;
        n_total++;
        if (bus.csr_mepc_o !== 32'h0)
            $display("FAIL reset_mepc got=%h exp=0", bus.csr_mepc_o);
        else n_pass++;
        n_total++;
        if (bus.global_int_en_o !== MSTATUS_RST[3])
            $display("FAIL reset_gie got=%b exp=%b", bus.global_int_en_o, MSTATUS_RST[3]);
        else n_pass++;
        n_total++;
        if (bus.ex_data_o !== MSTATUS_RST)
            $display("FAIL reset_read_mstatus got=%h exp=%h", bus.ex_data_o, MSTATUS_RST);
        else n_pass++;
        n_total++;
        if (bus.clint_data_o !== 32'h0)
            $display("FAIL reset_read_mcycle got=%h exp=0", bus.clint_data_o);
        else n_pass++;
    endtask

    task automatic test_cycle_counter();
        idle();
        repeat (10) cycle();
        bus.ex_raddr_i    = 32'hB00;
        bus.clint_raddr_i = 32'hB80;
        #1;
        n_total++;
        if (bus.ex_data_o !== 32'd10)
            $display("FAIL mcycle_after_10 got=%0d exp=10", bus.ex_data_o);
        else n_pass++;
        n_total++;
        if (bus.clint_data_o !== 32'd0)
            $display("FAIL mcycleh_after_10 got=%0d exp=0", bus.clint_data_o);
        else n_pass++;
        // Preload {0, FFFF_FFFF}: the next count carries into the upper half.
        idle();
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 32'hB80; bus.ex_data_i = 32'h0;
        cycle();
        bus.ex_waddr_i = 32'hB00; bus.ex_data_i = 32'hFFFF_FFFF;
        cycle();
        idle();
        cycle();
        bus.ex_raddr_i    = 32'hB00;
        bus.clint_raddr_i = 32'hB80;
        #1;
        n_total++;
        if ({bus.clint_data_o, bus.ex_data_o} !== 64'h1_0000_0000)
            $display("FAIL mcycle_carry got=%h_%h exp=00000001_00000000",
                     bus.clint_data_o, bus.ex_data_o);
        else n_pass++;
        // All-ones wraps silently to zero.
        idle();
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 32'hB80; bus.ex_data_i = 32'hFFFF_FFFF;
        cycle();
        bus.ex_waddr_i = 32'hB00; bus.ex_data_i = 32'hFFFF_FFFF;
        cycle();
        idle();
        cycle();
        bus.ex_raddr_i    = 32'hB00;
        bus.clint_raddr_i = 32'hB80;
        #1;
        n_total++;
        if ({bus.clint_data_o, bus.ex_data_o} !== 64'h0)
            $display("FAIL mcycle_wrap got=%h_%h exp=0", bus.clint_data_o, bus.ex_data_o);
        else n_pass++;
        // Writing the low half with no carry into the high half.
        idle();
        bus.clint_we_i = 1'b1; bus.clint_waddr_i = 32'hB00; bus.clint_data_i = 32'hFFFF_FFFF;
        cycle();
        idle();
        bus.ex_raddr_i = 32'hB00; bus.clint_raddr_i = 32'hB80;
        #1;
        n_total++;
        if ({bus.clint_data_o, bus.ex_data_o} !== {m_read(12'hB80), m_read(12'hB00)})
            $display("FAIL mcycle_write_lo got=%h_%h exp=%h_%h", bus.clint_data_o,
                     bus.ex_data_o, m_read(12'hB80), m_read(12'hB00));
        else n_pass++;
    endtask

    task automatic test_collision();
        idle();
        bus.ex_we_i    = 1'b1; bus.ex_waddr_i    = 32'h341; bus.ex_data_i    = 32'h100;
        bus.clint_we_i = 1'b1; bus.clint_waddr_i = 32'h341; bus.clint_data_i = 32'h200;
        bus.clint_raddr_i = 32'h341;
        #1;
        n_total++;
        if (bus.clint_data_o !== 32'h100)
            $display("FAIL collision_clint_bypass got=%h exp=100", bus.clint_data_o);
        else n_pass++;
        cycle();
        idle();
        #1;
        n_total++;
        if (bus.csr_mepc_o !== 32'h100)
            $display("FAIL collision_mepc got=%h exp=100", bus.csr_mepc_o);
        else n_pass++;
    endtask

    task automatic test_bypass();
        logic [31:0] old;
        idle();
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 32'h340; bus.ex_data_i = 32'h1234_5678;
        cycle();
        idle();
        old = m_read(12'h340);
        bus.ex_raddr_i = 32'h340;
        #1;
        n_total++;
        if (bus.ex_data_o !== old)
            $display("FAIL bypass_old got=%h exp=%h", bus.ex_data_o, old);
        else n_pass++;
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 32'hABC0_0340; bus.ex_data_i = 32'hDEAD_BEEF;
        #1;
        n_total++;
        if (bus.ex_data_o !== 32'hDEAD_BEEF)
            $display("FAIL bypass_same_cycle got=%h exp=deadbeef", bus.ex_data_o);
        else n_pass++;
        cycle();
        bus.ex_waddr_i = 32'h342; bus.ex_data_i = 32'h5555_AAAA;
        #1;
        n_total++;
        if (bus.ex_data_o !== 32'hDEAD_BEEF)
            $display("FAIL bypass_other_addr got=%h exp=deadbeef", bus.ex_data_o);
        else n_pass++;
        cycle();
    endtask

    task automatic test_int_enable();
        idle();
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 32'h300; bus.ex_data_i = 32'h0;
        cycle();
        idle();
        bus.clint_we_i = 1'b1; bus.clint_waddr_i = 32'h300; bus.clint_data_i = 32'h8;
        #1;
        n_total++;
        if (bus.global_int_en_o !== 1'b0)
            $display("FAIL gie_not_bypassed got=%b exp=0", bus.global_int_en_o);
        else n_pass++;
        cycle();
        idle();
        #1;
        n_total++;
        if (bus.global_int_en_o !== 1'b1)
            $display("FAIL gie_set got=%b exp=1", bus.global_int_en_o);
        else n_pass++;
        bus.clint_we_i = 1'b1; bus.clint_waddr_i = 32'h300; bus.clint_data_i = 32'h80;
        cycle();
        idle();
        bus.ex_raddr_i = 32'h300;
        #1;
        n_total++;
        if (bus.global_int_en_o !== 1'b0)
            $display("FAIL gie_clear got=%b exp=0", bus.global_int_en_o);
        else n_pass++;
        n_total++;
        if (bus.ex_data_o !== 32'h80)
            $display("FAIL mstatus_read got=%h exp=80", bus.ex_data_o);
        else n_pass++;
    endtask

    task automatic test_minstret();
        logic [11:0] pat;
        pat = 12'b1010_0101_0010;
        idle();
        for (int i = 0; i < 12; i++) begin
            bus.instret_i = pat[i];
            cycle();
        end
        idle();
        bus.ex_raddr_i = 32'hB02; bus.clint_raddr_i = 32'hB82;
        #1;
        n_total++;
        if (bus.ex_data_o !== 32'd5)
            $display("FAIL minstret_count got=%0d exp=5", bus.ex_data_o);
        else n_pass++;
        n_total++;
        if (bus.clint_data_o !== 32'd0)
            $display("FAIL minstreth_count got=%0d exp=0", bus.clint_data_o);
        else n_pass++;
    endtask

    task automatic test_unimpl();
        logic [11:0] plain [6];
        logic [31:0] snap [6];
        plain = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342};
        idle();
        bus.ex_raddr_i = 32'h7C0; bus.clint_raddr_i = 32'hFFFF_F7C0;
        #1;
        n_total++;
        if (bus.ex_data_o !== 32'h0 || bus.clint_data_o !== 32'h0)
            $display("FAIL unimpl_read got=%h/%h exp=0/0", bus.ex_data_o, bus.clint_data_o);
        else n_pass++;
        for (int i = 0; i < 6; i++) snap[i] = m_read(plain[i]);
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 32'h7C0; bus.ex_data_i = 32'h1234_5678;
        bus.ex_raddr_i = 32'h0;
        cycle();
        idle();
        for (int i = 0; i < 6; i++) begin
            bus.ex_raddr_i = {20'h0, plain[i]};
            #1;
            n_total++;
            if (bus.ex_data_o !== snap[i])
                $display("FAIL unimpl_write_%h got=%h exp=%h", plain[i], bus.ex_data_o, snap[i]);
            else n_pass++;
        end
        bus.ex_raddr_i = 32'h7C0;
        #1;
        n_total++;
        if (bus.ex_data_o !== 32'h0)
            $display("FAIL unimpl_read_after_write got=%h exp=0", bus.ex_data_o);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        idle();
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 32'h305; bus.ex_data_i = 32'h1000;
        cycle();
        idle();
        #1;
        n_total++;
        if (bus.csr_mtvec_o !== 32'h1000)
            $display("FAIL mtvec_write got=%h exp=1000", bus.csr_mtvec_o);
        else n_pass++;
        rst = 1'b1;
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 32'h305; bus.ex_data_i = 32'h2000;
        bus.instret_i = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        bus.ex_raddr_i = 32'hB00; bus.clint_raddr_i = 32'hB02;
        #1;
        n_total++;
        if (bus.csr_mtvec_o !== MTVEC_RST)
            $display("FAIL mid_reset_mtvec got=%h exp=%h", bus.csr_mtvec_o, MTVEC_RST);
        else n_pass++;
        n_total++;
        if (bus.ex_data_o !== 32'h0 || bus.clint_data_o !== 32'h0)
            $display("FAIL mid_reset_counters got=%h/%h exp=0/0", bus.ex_data_o, bus.clint_data_o);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [11:0] addrs [12];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h123};
        for (int i = 0; i < 400; i++) begin
            bus.instret_i     = 1'($urandom_range(0, 1));
            bus.ex_we_i       = ($urandom_range(0, 3) == 0);
            bus.ex_waddr_i    = {20'($urandom), addrs[$urandom_range(0, 11)]};
            bus.ex_raddr_i    = {20'($urandom), addrs[$urandom_range(0, 11)]};
            bus.ex_data_i     = $urandom;
            bus.clint_we_i    = ($urandom_range(0, 2) == 0);
            bus.clint_waddr_i = {20'($urandom), addrs[$urandom_range(0, 11)]};
            bus.clint_raddr_i = {20'($urandom), addrs[$urandom_range(0, 11)]};
            bus.clint_data_i  = $urandom;
            if ($urandom_range(0, 7) == 0) bus.ex_raddr_i = bus.ex_waddr_i;
            if ($urandom_range(0, 7) == 0) bus.clint_raddr_i = bus.clint_waddr_i;
            #1;
            n_total++;
            if (bus.ex_data_o !== exp_ex())
                $display("FAIL rnd_ex_read[%0d] got=%h exp=%h", i, bus.ex_data_o, exp_ex());
            else n_pass++;
            n_total++;
            if (bus.clint_data_o !== exp_clint())
                $display("FAIL rnd_clint_read[%0d] got=%h exp=%h", i, bus.clint_data_o, exp_clint());
            else n_pass++;
            n_total++;
            if (bus.csr_mtvec_o !== m_csr[12'h305] || bus.csr_mepc_o !== m_csr[12'h341] ||
                bus.csr_mstatus_o !== m_csr[12'h300] ||
                bus.global_int_en_o !== m_csr[12'h300][3])
                $display("FAIL rnd_views[%0d] got=%h/%h/%h/%b exp=%h/%h/%h", i,
                         bus.csr_mtvec_o, bus.csr_mepc_o, bus.csr_mstatus_o,
                         bus.global_int_en_o, m_csr[12'h305], m_csr[12'h341], m_csr[12'h300]);
            else n_pass++;
            cycle();
        end
        idle();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        idle();
        model_reset();
        test_reset();
        test_cycle_counter();
        test_collision();
        test_bypass();
        test_int_enable();
        test_minstret();
        test_unimpl();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
